// File: rtl/usb_input_words_if.sv
// Word stream between the USB byte reader and its consumer.
// A transfer happens on every clock edge where valid and ready are both high.
interface usb_input_words_if #(
    parameter int W = 16
) ();
    logic [W-1:0] out;
    logic         valid;
    logic         ready;

    modport master (output out, output valid, input ready);
    modport slave  (input out, input valid, output ready);
endinterface

// File: rtl/usb_input_words.sv
// FT245-style USB FIFO reader: qualifies RXF#, strobes RD# with fixed timing,
// packs bytes into words and buffers them in a show-ahead FIFO.
module usb_input_words #(
    parameter int BYTES_PER_WORD   = 2,
    parameter bit LITTLE_ENDIAN    = 1'b1,
    parameter int RXF_CHECKS       = 3,
    parameter int RD_LOW_CYCLES    = 4,
    parameter int PRECHARGE_CYCLES = 6,
    parameter int FIFO_DEPTH       = 8,
    localparam int W  = 8 * BYTES_PER_WORD,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data,
    input  logic                rxf,
    output logic                rd,
    input  logic                flush,
    usb_input_words_if.master   words,
    output logic [AW:0]         level,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STROBE    = 2'd1,
        S_PRECHARGE = 2'd2,
        S_UNUSED    = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic                           rxf_meta_q, rxf_s_q;
    logic [3:0]                     qual_q, qual_d;
    logic [3:0]                     tim_q, tim_d;
    logic                           rd_q, rd_d;
    logic                           discard_q, discard_d;
    logic [BW-1:0]                  byte_idx_q, byte_idx_d;
    logic [BYTES_PER_WORD-1:0][7:0] bytes_q, bytes_d;
    logic [AW:0]                    wr_ptr_q, wr_ptr_d;
    logic [AW:0]                    rd_ptr_q, rd_ptr_d;
    logic [W-1:0]                   out_q, out_d;
    logic [W-1:0]                   mem_q [FIFO_DEPTH];

    logic          capture;
    logic          keep_byte;
    logic          last_byte;
    logic          push;
    logic          pop;
    logic          full;
    logic          valid_int;
    logic [AW:0]   level_int;
    logic [AW-1:0] head_next_idx;
    logic [W-1:0]  word_full;

    assign level_int     = wr_ptr_q - rd_ptr_q;
    assign full          = (level_int == (AW+1)'(FIFO_DEPTH));
    assign valid_int     = (level_int != '0);
    assign head_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign last_byte     = (byte_idx_q == BW'(BYTES_PER_WORD - 1));

    // Read-strobe sequencer
    always_comb begin
        state_d   = state_q;
        qual_d    = qual_q;
        tim_d     = tim_q;
        rd_d      = rd_q;
        discard_d = discard_q;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                rd_d = 1'b1;
                if (!rxf_s_q && !full) begin
                    if (qual_q == 4'(RXF_CHECKS - 1)) begin
                        state_d = S_STROBE;
                        rd_d    = 1'b0;
                        qual_d  = '0;
                        tim_d   = '0;
                    end else begin
                        qual_d = qual_q + 4'd1;
                    end
                end else begin
                    qual_d = '0;
                end
            end
            S_STROBE: begin
                // A flush mid-strobe lets the bus cycle finish but drops the byte.
                if (flush) discard_d = 1'b1;
                if (tim_q == 4'(RD_LOW_CYCLES - 1)) begin
                    capture   = 1'b1;
                    rd_d      = 1'b1;
                    tim_d     = '0;
                    discard_d = 1'b0;
                    state_d   = S_PRECHARGE;
                end else begin
                    tim_d = tim_q + 4'd1;
                end
            end
            S_PRECHARGE: begin
                if (tim_q == 4'(PRECHARGE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    tim_d   = '0;
                    qual_d  = '0;
                end else begin
                    tim_d = tim_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b1;
                tim_d   = '0;
                qual_d  = '0;
            end
        endcase
    end

    // The final byte of a word comes straight from the pins on the push edge.
    always_comb begin
        word_full = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (LITTLE_ENDIAN)
                word_full[8*i +: 8] = (i == BYTES_PER_WORD - 1) ? data : bytes_q[i];
            else
                word_full[8*(BYTES_PER_WORD-1-i) +: 8] = (i == BYTES_PER_WORD - 1) ? data : bytes_q[i];
        end
    end

    always_comb begin
        keep_byte  = capture && !discard_q && !flush;
        byte_idx_d = byte_idx_q;
        bytes_d    = bytes_q;
        push       = 1'b0;
        if (keep_byte) begin
            bytes_d[byte_idx_q] = data;
            if (last_byte) begin
                push       = 1'b1;
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + BW'(1);
            end
        end
        if (flush) byte_idx_d = '0;
    end

    // Output FIFO pointers and the registered show-ahead head word
    always_comb begin
        pop      = valid_int && words.ready && !flush;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        out_d    = out_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            out_d    = '0;
        end else if (pop) begin
            if (level_int > (AW+1)'(1))
                out_d = mem_q[head_next_idx];
            else if (push)
                out_d = word_full;
        end else if (push && !valid_int) begin
            out_d = word_full;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rxf_meta_q <= 1'b1;
            rxf_s_q    <= 1'b1;
            qual_q     <= '0;
            tim_q      <= '0;
            rd_q       <= 1'b1;
            discard_q  <= 1'b0;
            byte_idx_q <= '0;
            bytes_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            rxf_meta_q <= rxf;
            rxf_s_q    <= rxf_meta_q;
            qual_q     <= qual_d;
            tim_q      <= tim_d;
            rd_q       <= rd_d;
            discard_q  <= discard_d;
            byte_idx_q <= byte_idx_d;
            bytes_q    <= bytes_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_q      <= out_d;
        end
    end

    assign rd          = rd_q;
    assign words.out   = out_q;
    assign words.valid = valid_int;
    assign level       = level_int;
    assign state       = state_q;

endmodule

// File: tb/tb_usb_input_words.sv
// Directed bench for usb_input_words: default 2-byte little-endian instance
// plus a 4-byte big-endian instance.
module tb_usb_input_words;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_a = 8'h00, data_b = 8'h00;
    logic        rxf_a = 1'b1, rxf_b = 1'b1;
    logic        flush_a = 1'b0, flush_b = 1'b0;
    logic        rd_a, rd_b;
    logic [3:0]  level_a, level_b;
    logic [1:0]  state_a, state_b;

    usb_input_words_if #(.W(16)) if_a ();
    usb_input_words_if #(.W(32)) if_b ();

    usb_input_words dut_a (
        .clk(clk), .reset(reset), .data(data_a), .rxf(rxf_a), .rd(rd_a),
        .flush(flush_a), .words(if_a), .level(level_a), .state(state_a)
    );

    usb_input_words #(.BYTES_PER_WORD(4), .LITTLE_ENDIAN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .data(data_b), .rxf(rxf_b), .rd(rd_b),
        .flush(flush_b), .words(if_b), .level(level_b), .state(state_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  src_a[$];
    logic [7:0]  src_b[$];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    int cyc = 0;
    int falls_a = 0, rises_a = 0, fall_cyc_a = -1, last_low_a = 0, last_period_a = 0;
    int falls_b = 0;
    logic rd_prev_a = 1'b1, rd_prev_b = 1'b1;

    // USB FIFO model: presents the next byte when RD# falls; also measures RD# timing.
    always @(negedge clk) begin
        if (rd_prev_a && !rd_a) begin
            falls_a++;
            if (fall_cyc_a >= 0) last_period_a = cyc - fall_cyc_a;
            fall_cyc_a = cyc;
            if (src_a.size() > 0) data_a = src_a.pop_front();
        end
        if (!rd_prev_a && rd_a) begin
            rises_a++;
            last_low_a = cyc - fall_cyc_a;
        end
        if (rd_prev_b && !rd_b) begin
            falls_b++;
            if (src_b.size() > 0) data_b = src_b.pop_front();
        end
        rd_prev_a = rd_a;
        rd_prev_b = rd_b;
        cyc++;
    end

    always @(posedge clk) begin
        if (if_a.valid === 1'b1 && if_a.ready === 1'b1) got_q.push_back(if_a.out);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] pop_got();
        if (got_q.size() > 0) return got_q.pop_front();
        return 16'hxxxx;
    endfunction

    int base;

    initial begin
        if_a.ready = 1'b0;
        if_b.ready = 1'b0;

        // Reset state
        tick(3);
        check("rst_rd", rd_a, 1);
        check("rst_valid", if_a.valid, 0);
        check("rst_level", level_a, 0);
        check("rst_out", if_a.out, 0);
        check("rst_state", state_a, 0);
        check("rst_out_b", if_b.out, 0);
        reset = 1'b0;
        tick(3);

        // Four bytes, consumer always ready
        if_a.ready = 1'b1;
        src_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = '{16'h2211, 16'h4433};
        rxf_a = 1'b0;
        for (int k = 0; k < 300 && falls_a < 4; k++) tick();
        check("t1_falls", falls_a, 4);
        rxf_a = 1'b0;
        rxf_a = 1'b1;
        for (int k = 0; k < 50 && rises_a < 4; k++) tick();
        tick(5);
        check("t1_low", last_low_a, 4);
        check("t1_period", last_period_a, 13);
        check("t1_nwords", got_q.size(), 2);
        while (exp_q.size() > 0) check("t1_word", pop_got(), exp_q.pop_front());
        check("t1_level", level_a, 0);
        check("t1_valid", if_a.valid, 0);

        // Two-cycle RXF# glitch must not start a read
        tick(20);
        base = falls_a;
        rxf_a = 1'b0;
        tick(2);
        rxf_a = 1'b1;
        tick(20);
        check("glitch_falls", falls_a - base, 0);
        check("glitch_rd", rd_a, 1);
        check("glitch_level", level_a, 0);

        // Saturation with consumer stalled
        got_q.delete();
        if_a.ready = 1'b0;
        for (int i = 1; i <= 20; i++) src_a.push_back(8'(i));
        base = falls_a;
        rxf_a = 1'b0;
        for (int k = 0; k < 600 && level_a != 8; k++) tick();
        check("sat_level", level_a, 8);
        check("sat_falls", falls_a - base, 16);
        tick(40);
        check("sat_falls_hold", falls_a - base, 16);
        check("sat_rd_high", rd_a, 1);
        check("sat_head", if_a.out, 16'h0201);
        check("sat_valid", if_a.valid, 1);
        if_a.ready = 1'b1;
        tick();
        if_a.ready = 1'b0;
        check("sat_pop_level", level_a, 7);
        check("sat_pop_head", if_a.out, 16'h0403);
        check("sat_pop_word", pop_got(), 16'h0201);
        for (int k = 0; k < 80 && level_a != 8; k++) tick();
        check("sat_refill_level", level_a, 8);
        check("sat_refill_falls", falls_a - base, 18);
        rxf_a = 1'b1;
        tick(20);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        check("flush_level", level_a, 0);
        check("flush_valid", if_a.valid, 0);
        check("flush_out", if_a.out, 0);
        src_a.delete();

        // Flush in the second strobe cycle of a word's second byte
        src_a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
        base = falls_a;
        rxf_a = 1'b0;
        for (int k = 0; k < 300 && falls_a != base + 8; k++) tick();
        check("fl_falls", falls_a - base, 8);
        check("fl_pre_level", level_a, 3);
        tick();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        check("fl_level", level_a, 0);
        check("fl_valid", if_a.valid, 0);
        for (int k = 0; k < 10 && rd_a != 1'b1; k++) tick();
        check("fl_low", last_low_a, 4);
        for (int k = 0; k < 100 && level_a != 1; k++) tick();
        rxf_a = 1'b1;
        check("fl_next_level", level_a, 1);
        check("fl_next_word", if_a.out, 16'hC2C1);
        tick(20);

        // Reset during a strobe
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        src_a = '{8'h55, 8'hD1, 8'hD2};
        base = falls_a;
        rxf_a = 1'b0;
        for (int k = 0; k < 100 && falls_a != base + 1; k++) tick();
        tick();
        reset = 1'b1;
        tick();
        check("rs_rd", rd_a, 1);
        check("rs_state", state_a, 0);
        check("rs_level", level_a, 0);
        reset = 1'b0;
        for (int k = 0; k < 200 && level_a != 1; k++) tick();
        rxf_a = 1'b1;
        check("rs_resume_level", level_a, 1);
        check("rs_resume_word", if_a.out, 16'hD2D1);
        check("rs_resume_falls", falls_a - base, 3);

        // Big-endian, 4 bytes per word
        src_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        rxf_b = 1'b0;
        for (int k = 0; k < 200 && falls_b < 4; k++) tick();
        rxf_b = 1'b1;
        for (int k = 0; k < 60 && level_b != 1; k++) tick();
        check("be_word", if_b.out, 32'hDEADBEEF);
        check("be_valid", if_b.valid, 1);
        tick(40);
        check("be_level", level_b, 1);
        check("be_falls", falls_b, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
